// File: rtl/mips_ctrl_pkg.sv
// Shared MIPS control definitions: opcode encodings, hazard sequencer state, widths.
package mips_ctrl_pkg;

  localparam int unsigned OP_W     = 6;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned HS_CNT_W = 4;

  localparam logic [OP_W-1:0] OP_HLT       = 6'b010001;
  localparam logic [OP_W-1:0] OP_LD        = 6'b010100;
  localparam logic [OP_W-1:0] OP_JUMP_MASK = 6'b111100;
  localparam logic [OP_W-1:0] OP_JUMP_VAL  = 6'b011100;

  typedef enum logic [1:0] {
    HS_RUN  = 2'd0,
    HS_LD   = 2'd1,
    HS_JMP  = 2'd2,
    HS_HALT = 2'd3
  } hs_state_t;

  // Jump family ignores the two low opcode bits.
  function automatic logic is_jump(input logic [OP_W-1:0] op);
    return (op & OP_JUMP_MASK) == OP_JUMP_VAL;
  endfunction

endpackage

// File: rtl/hazard_sequencer_if.sv
// IF/ID-side hazard bus: decoded instruction fields in, stall controls out.
interface hazard_sequencer_if;
  import mips_ctrl_pkg::*;

  logic [OP_W-1:0]  op;
  logic [REG_W-1:0] rs;
  logic [REG_W-1:0] rt;
  logic             resume;
  logic             stall;
  logic             stall_pm;
  logic             halted;
  logic             busy;

  modport master (output op, rs, rt, resume, input stall, stall_pm, halted, busy);
  modport slave  (input op, rs, rt, resume, output stall, stall_pm, halted, busy);

endinterface

// File: rtl/hazard_sequencer_bubble.sv
// Loadable down counter that tracks the remaining bubble cycles.
module bubble_counter
  import mips_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [HS_CNT_W-1:0] load_val,
  input  logic                dec,
  output logic [HS_CNT_W-1:0] cnt,
  output logic                zero_c
);

  // Load has priority over decrement; the count saturates at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - HS_CNT_W'(1);
    end
  end

  assign zero_c = (cnt == '0);

endmodule

// File: rtl/hazard_sequencer.sv
// Hazard sequencer: inserts halt, jump and load bubbles for the instruction in IF/ID.
// Optional feature: define HAZARD_SEQ_LOAD_USE_EN to stall only true load-use
// dependencies instead of every load.
module hazard_sequencer
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned JUMP_BUBBLES = 2,
  parameter int unsigned LOAD_BUBBLES = 1
)(
  input  logic              clk,
  input  logic              reset,
  hazard_sequencer_if.slave bus
);

  localparam logic [HS_CNT_W-1:0] JUMP_RELOAD = HS_CNT_W'(JUMP_BUBBLES - 1);
  localparam logic [HS_CNT_W-1:0] LOAD_RELOAD = HS_CNT_W'(LOAD_BUBBLES - 1);

`ifdef HAZARD_SEQ_LOAD_USE_EN
  // A load-use stall leaves the consumer to be decoded normally afterwards.
  localparam logic LD_EXIT_SERVICED = 1'b0;
`else
  localparam logic LD_EXIT_SERVICED = 1'b1;
`endif

  hs_state_t           state;
  hs_state_t           state_n;
  logic                serviced;
  logic                serviced_n;
  logic                stall_c;
  logic                busy_c;
  logic                stall_pm_q;
  logic                halted_q;
  logic                cnt_load;
  logic                cnt_dec;
  logic [HS_CNT_W-1:0] cnt_val;
  logic [HS_CNT_W-1:0] cnt;
  logic                cnt_zero_c;
  logic                op_hlt_c;
  logic                op_jump_c;
  logic                op_ld_c;
  logic                ld_hit_c;

  assign op_hlt_c  = (bus.op == OP_HLT);
  assign op_jump_c = is_jump(bus.op);
  assign op_ld_c   = (bus.op == OP_LD);

`ifdef HAZARD_SEQ_LOAD_USE_EN
  logic             ld_pending;
  logic             ld_pending_n;
  logic [REG_W-1:0] ld_dst;
  logic [REG_W-1:0] ld_dst_n;
  logic             ld_set_c;

  // Consumer check only applies to a fresh (non-serviced) RUN decode.
  assign ld_hit_c = (state == HS_RUN) && !serviced && ld_pending &&
                    (ld_dst != '0) && ((bus.rs == ld_dst) || (bus.rt == ld_dst));
`else
  logic unused_operands;

  assign ld_hit_c        = 1'b0;
  assign unused_operands = ^{bus.rs, bus.rt};
`endif

  bubble_counter u_bubble_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .zero_c   (cnt_zero_c)
  );

  // Next-state and stall decode; the triggering cycle is the first bubble.
  always_comb begin
    state_n    = state;
    serviced_n = 1'b0;
    stall_c    = 1'b0;
    cnt_load   = 1'b0;
    cnt_val    = '0;
    cnt_dec    = 1'b0;
`ifdef HAZARD_SEQ_LOAD_USE_EN
    ld_set_c   = 1'b0;
`endif
    unique case (state)
      HS_RUN: begin
        if (!serviced) begin
          if (ld_hit_c) begin
            stall_c = 1'b1;
            if (LOAD_BUBBLES > 1) begin
              state_n  = HS_LD;
              cnt_load = 1'b1;
              cnt_val  = LOAD_RELOAD;
            end
          end else if (op_hlt_c) begin
            stall_c = 1'b1;
            state_n = HS_HALT;
          end else if (op_jump_c) begin
            stall_c = 1'b1;
            if (JUMP_BUBBLES > 1) begin
              state_n  = HS_JMP;
              cnt_load = 1'b1;
              cnt_val  = JUMP_RELOAD;
            end else begin
              serviced_n = 1'b1;
            end
          end else if (op_ld_c) begin
`ifdef HAZARD_SEQ_LOAD_USE_EN
            ld_set_c = 1'b1;
`else
            stall_c = 1'b1;
            if (LOAD_BUBBLES > 1) begin
              state_n  = HS_LD;
              cnt_load = 1'b1;
              cnt_val  = LOAD_RELOAD;
            end else begin
              serviced_n = 1'b1;
            end
`endif
          end
        end
      end
      HS_LD, HS_JMP: begin
        stall_c = !cnt_zero_c;
        cnt_dec = 1'b1;
        if (cnt <= HS_CNT_W'(1)) begin
          state_n    = HS_RUN;
          serviced_n = (state == HS_JMP) || LD_EXIT_SERVICED;
        end
      end
      HS_HALT: begin
        stall_c = 1'b1;
        if (bus.resume) begin
          state_n    = HS_RUN;
          serviced_n = 1'b1;
        end
      end
      default: state_n = HS_RUN;
    endcase
  end

  // Sequencer state and registered stall/halt outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= HS_RUN;
      serviced   <= 1'b0;
      stall_pm_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state      <= state_n;
      serviced   <= serviced_n;
      stall_pm_q <= stall_c;
      halted_q   <= (state_n == HS_HALT);
    end
  end

`ifdef HAZARD_SEQ_LOAD_USE_EN
  // Pending load lives one decode cycle; stalled cycles keep it alive.
  always_comb begin
    ld_pending_n = ld_pending;
    ld_dst_n     = ld_dst;
    if (ld_hit_c) begin
      ld_pending_n = 1'b0;
    end else if (ld_set_c) begin
      ld_pending_n = 1'b1;
      ld_dst_n     = bus.rt;
    end else if (!stall_c) begin
      ld_pending_n = 1'b0;
    end
  end

  // Pending load destination register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ld_pending <= 1'b0;
      ld_dst     <= '0;
    end else begin
      ld_pending <= ld_pending_n;
      ld_dst     <= ld_dst_n;
    end
  end
`endif

  assign busy_c       = (state == HS_LD) || (state == HS_JMP);
  assign bus.stall    = stall_c;
  assign bus.busy     = busy_c;
  assign bus.stall_pm = stall_pm_q;
  assign bus.halted   = halted_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Bench for hazard_sequencer: two parameterisations driven in lockstep, checked
// against a bubble-count reference model, a vector table and corner sequences.
module tb_hazard_sequencer;

  localparam logic [5:0] HLT  = 6'b010001;
  localparam logic [5:0] LD   = 6'b010100;
  localparam logic [5:0] JMPA = 6'b011101;
  localparam logic [5:0] JMPB = 6'b011110;

  typedef struct {
    int         rem;       // stall cycles still owed after the current one
    bit         svc;       // next decode is ignored
    bit         halt;
    bit         exit_svc;
    bit         pend;
    logic [4:0] dst;
    bit         prev_stall;
  } mdl_t;

  typedef struct {
    logic [5:0] op;
    logic       res;
    logic       s;
    logic       pm;
    logic       h;
    logic       b;
  } vec_t;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  mdl_t ma;
  mdl_t mb;
  vec_t tbl[$];

  hazard_sequencer_if ifa ();
  hazard_sequencer_if ifb ();

  hazard_sequencer #(.JUMP_BUBBLES(2), .LOAD_BUBBLES(1)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa)
  );
  hazard_sequencer #(.JUMP_BUBBLES(1), .LOAD_BUBBLES(3)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle of the reference: count owed stalls rather than track states.
  task automatic mstep(input int jb, input int lb, inout mdl_t m,
                       input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic res, output logic es, output logic ep,
                       output logic eh, output logic eb);
    bit hit;
`ifdef HAZARD_SEQ_LOAD_USE_EN
    bit set;
    set = 0;
`endif
    hit = 0;
    ep  = m.prev_stall;
    eh  = m.halt;
    eb  = (m.rem > 0);
    es  = 1'b0;
    if (m.halt) begin
      es = 1'b1;
      if (res) begin
        m.halt = 0;
        m.svc  = 1;
      end
    end else if (m.rem > 0) begin
      es    = 1'b1;
      m.rem = m.rem - 1;
      if (m.rem == 0) m.svc = m.exit_svc;
    end else if (m.svc) begin
      m.svc = 0;
    end else begin
`ifdef HAZARD_SEQ_LOAD_USE_EN
      hit = m.pend && (m.dst != 0) && ((rs == m.dst) || (rt == m.dst));
`endif
      if (hit) begin
        es         = 1'b1;
        m.rem      = lb - 1;
        m.exit_svc = 0;
      end else if (op == HLT) begin
        es     = 1'b1;
        m.halt = 1;
      end else if (op[5:2] == 4'b0111) begin
        es         = 1'b1;
        m.rem      = jb - 1;
        m.exit_svc = 1;
        m.svc      = (jb == 1);
      end else if (op == LD) begin
`ifdef HAZARD_SEQ_LOAD_USE_EN
        set = 1;
`else
        es         = 1'b1;
        m.rem      = lb - 1;
        m.exit_svc = 1;
        m.svc      = (lb == 1);
`endif
      end
    end
`ifdef HAZARD_SEQ_LOAD_USE_EN
    if (hit) m.pend = 0;
    else if (set) begin
      m.pend = 1;
      m.dst  = rt;
    end else if (!es) m.pend = 0;
`endif
    m.prev_stall = es;
  endtask

  // Drive one decode cycle on both DUTs and check them against the model.
  task automatic cycle(input logic [5:0] op_i, input logic [4:0] rs_i,
                       input logic [4:0] rt_i, input logic res_i);
    logic es, ep, eh, eb;
    @(negedge clk);
    ifa.op = op_i; ifa.rs = rs_i; ifa.rt = rt_i; ifa.resume = res_i;
    ifb.op = op_i; ifb.rs = rs_i; ifb.rt = rt_i; ifb.resume = res_i;
    #1;
    mstep(2, 1, ma, op_i, rs_i, rt_i, res_i, es, ep, eh, eb);
    chk("a_stall", ifa.stall, es);
    chk("a_stall_pm", ifa.stall_pm, ep);
    chk("a_halted", ifa.halted, eh);
    chk("a_busy", ifa.busy, eb);
    mstep(1, 3, mb, op_i, rs_i, rt_i, res_i, es, ep, eh, eb);
    chk("b_stall", ifb.stall, es);
    chk("b_stall_pm", ifb.stall_pm, ep);
    chk("b_halted", ifb.halted, eh);
    chk("b_busy", ifb.busy, eb);
  endtask

  // Asynchronous reset inside the current cycle; outputs must clear at once.
  task automatic mid_reset();
    ifa.op = 6'h00; ifb.op = 6'h00;
    #1 reset = 1'b0;
    #1;
    chk("rst_a_stall", ifa.stall, 1'b0);
    chk("rst_a_stall_pm", ifa.stall_pm, 1'b0);
    chk("rst_a_halted", ifa.halted, 1'b0);
    chk("rst_a_busy", ifa.busy, 1'b0);
    chk("rst_b_stall_pm", ifb.stall_pm, 1'b0);
    chk("rst_b_halted", ifb.halted, 1'b0);
    @(posedge clk);
    #2 reset = 1'b1;
    ma = '{default: 0};
    mb = '{default: 0};
  endtask

  function automatic void add(input logic [5:0] op, input logic res, input logic s,
                              input logic pm, input logic h, input logic b);
    vec_t v;
    v.op = op; v.res = res; v.s = s; v.pm = pm; v.h = h; v.b = b;
    tbl.push_back(v);
  endfunction

  initial begin
    logic [5:0] op_r;
    n_vec = 0;
    n_err = 0;
    ma = '{default: 0};
    mb = '{default: 0};
    reset = 1'b0;
    ifa.op = 6'h00; ifa.rs = '0; ifa.rt = '0; ifa.resume = 1'b0;
    ifb.op = 6'h00; ifb.rs = '0; ifb.rt = '0; ifb.resume = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    chk("init_stall", ifa.stall, 1'b0);
    chk("init_stall_pm", ifa.stall_pm, 1'b0);
    chk("init_halted", ifa.halted, 1'b0);
    chk("init_busy", ifa.busy, 1'b0);

    // Vector table for the default-parameter DUT (jump 2, load 1).
    add(6'h00, 0, 0, 0, 0, 0);
    add(JMPA,  0, 1, 0, 0, 0);
    add(JMPA,  0, 1, 1, 0, 1);
    add(JMPA,  0, 0, 1, 0, 0);
    add(JMPA,  0, 1, 0, 0, 0);
    add(6'h00, 0, 1, 1, 0, 1);
    add(6'h00, 0, 0, 1, 0, 0);
`ifndef HAZARD_SEQ_LOAD_USE_EN
    add(LD,    0, 1, 0, 0, 0);
    add(LD,    0, 0, 1, 0, 0);
    add(LD,    0, 1, 0, 0, 0);
    add(6'h00, 0, 0, 1, 0, 0);
`endif
    add(HLT,   0, 1, 0, 0, 0);
    add(HLT,   0, 1, 1, 1, 0);
    add(HLT,   0, 1, 1, 1, 0);
    add(HLT,   1, 1, 1, 1, 0);
    add(HLT,   0, 0, 1, 0, 0);
    add(HLT,   0, 1, 0, 0, 0);
    add(6'h00, 1, 1, 1, 1, 0);
    add(6'h00, 0, 0, 1, 0, 0);
    add(6'h00, 1, 0, 0, 0, 0);
    add(JMPB,  1, 1, 0, 0, 0);
    add(6'h00, 1, 1, 1, 0, 1);
    add(6'h00, 0, 0, 1, 0, 0);
    foreach (tbl[i]) begin
      cycle(tbl[i].op, 5'd0, 5'd0, tbl[i].res);
      chk($sformatf("tbl%0d_stall", i), ifa.stall, tbl[i].s);
      chk($sformatf("tbl%0d_stall_pm", i), ifa.stall_pm, tbl[i].pm);
      chk($sformatf("tbl%0d_halted", i), ifa.halted, tbl[i].h);
      chk($sformatf("tbl%0d_busy", i), ifa.busy, tbl[i].b);
    end

    // Reset in the middle of a jump bubble, then a clean NOP.
    cycle(JMPA, 5'd0, 5'd0, 1'b0);
    cycle(6'h00, 5'd0, 5'd0, 1'b0);
    chk("midjmp_busy", ifa.busy, 1'b1);
    mid_reset();
    cycle(6'h00, 5'd0, 5'd0, 1'b0);
    chk("postrst_stall", ifa.stall, 1'b0);

    // Reset while halted.
    cycle(HLT, 5'd0, 5'd0, 1'b0);
    cycle(HLT, 5'd0, 5'd0, 1'b0);
    chk("midhlt_halted", ifa.halted, 1'b1);
    mid_reset();
    cycle(6'h00, 5'd0, 5'd0, 1'b0);

`ifndef HAZARD_SEQ_LOAD_USE_EN
    // Three-bubble load, then single-bubble jumps, on the second DUT.
    cycle(LD, 5'd0, 5'd0, 1'b0);    chk("b_ld0", ifb.stall, 1'b1);
    cycle(LD, 5'd0, 5'd0, 1'b0);    chk("b_ld1", ifb.stall, 1'b1);
    cycle(LD, 5'd0, 5'd0, 1'b0);    chk("b_ld2", ifb.stall, 1'b1);
    cycle(6'h00, 5'd0, 5'd0, 1'b0); chk("b_ld3", ifb.stall, 1'b0);
`else
    // Load-use: dependent consumer stalls once, independent ones do not.
    cycle(LD, 5'd0, 5'd5, 1'b0);    chk("lu_ld", ifa.stall, 1'b0);
    cycle(6'h00, 5'd5, 5'd0, 1'b0); chk("lu_use", ifa.stall, 1'b1);
    cycle(6'h00, 5'd5, 5'd0, 1'b0); chk("lu_after", ifa.stall, 1'b0);
    cycle(LD, 5'd0, 5'd0, 1'b0);    chk("lu_r0_ld", ifa.stall, 1'b0);
    cycle(6'h00, 5'd0, 5'd0, 1'b0); chk("lu_r0_use", ifa.stall, 1'b0);
    repeat (4) cycle(6'h00, 5'd0, 5'd0, 1'b0);
    cycle(LD, 5'd0, 5'd7, 1'b0);    chk("lu_j_ld", ifa.stall, 1'b0);
    cycle(JMPA, 5'd0, 5'd7, 1'b0);  chk("lu_j0", ifa.stall, 1'b1);
    cycle(JMPA, 5'd0, 5'd7, 1'b0);  chk("lu_j1", ifa.stall, 1'b1);
    cycle(JMPA, 5'd0, 5'd7, 1'b0);  chk("lu_j2", ifa.stall, 1'b1);
    cycle(6'h00, 5'd0, 5'd0, 1'b0); chk("lu_j3", ifa.stall, 1'b0);
    repeat (4) cycle(6'h00, 5'd0, 5'd0, 1'b0);
`endif
    cycle(JMPB, 5'd0, 5'd0, 1'b0);  chk("b_j0", ifb.stall, 1'b1);
    cycle(JMPB, 5'd0, 5'd0, 1'b0);  chk("b_j1", ifb.stall, 1'b0);
    cycle(JMPB, 5'd0, 5'd0, 1'b0);  chk("b_j2", ifb.stall, 1'b1);

    // Randomised traffic with held opcodes and occasional resets.
    op_r = 6'h00;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        case ($urandom_range(0, 5))
          0: op_r = HLT;
          1: op_r = LD;
          2: op_r = {4'b0111, 2'($urandom_range(0, 3))};
          3: op_r = 6'($urandom_range(0, 63));
          default: op_r = 6'h00;
        endcase
      end
      cycle(op_r, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 199) == 0) mid_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_sequencer.md
# hazard_sequencer

Pipeline hazard sequencer for the MIPS core: decodes the opcode held in the IF/ID register and inserts bubbles for halt, jump and load hazards. It uses a small state machine with a programmable bubble counter, so the bubble counts are configurable. It drives the stall lines consumed by the PC, IF/ID and program-memory logic, and sits between the IF/ID register and the hazard inputs of the fetch stage.

## Interface
- JUMP_BUBBLES, 2, stall cycles per jump; legal 1..15
- LOAD_BUBBLES, 1, stall cycles per load hazard; legal 1..15

- clk  in  1  core clock; all state on rising edge
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately
- op  in  6  opcode of instruction in IF/ID
- rs  in  5  source register 1 of instruction in IF/ID
- rt  in  5  source register 2 / load destination of instruction in IF/ID
- resume  in  1  single-cycle pulse; releases HALT
- stall  out  1  combinational; 1 holds PC and IF/ID this cycle
- stall_pm  out  1  stall registered by one cycle; holds program memory
- halted  out  1  registered; 1 while in HALT
- busy  out  1  combinational; 1 in LD or JMP state

## Operation
- Opcode decode:
  - HLT = 6'b010001
  - LD = 6'b010100
  - JUMP = 6'b0111xx, where op[1:0] is don't-care
  - Priority HLT > JUMP > LD.
- States: RUN, LD, JMP, HALT.
- 4-bit down counter `cnt`.
- Flag `serviced`: when set, the op in decode has already had its bubbles, so op is ignored for one cycle. The flag clears at the end of that cycle.
- RUN, not serviced:
  - HLT: stall=1, go to HALT.
  - JUMP: stall=1, go to JMP, cnt=JUMP_BUBBLES-1.
  - LD: handling depends on the Configuration macro.
  - Otherwise: stall=0.
- LD or JMP state:
  - stall=1 while cnt>0; cnt decrements each cycle.
  - When cnt==0 and the state is entered from a bubble-count of 1, stall=0 and the bubble counts are complete.
  - On exit, return to RUN with serviced=1 (except load-use exit, see Configuration).
  - Bubble count is exact: the triggering cycle plus subsequent cycles total JUMP_BUBBLES or LOAD_BUBBLES stall cycles.
  - The cycle after the last stall cycle is a serviced RUN cycle.
- HALT:
  - stall=1 and halted=1 indefinitely.
  - resume=1 → RUN with serviced=1, so the HLT still in IF/ID does not retrigger.
  - resume is ignored in every other state.
- stall_pm tracks stall with a one-cycle delay.
- Reset, asynchronous, including mid-bubble or mid-halt:
  - state=RUN, cnt=0, serviced=0, ld_pending=0, ld_dst=0, stall_pm=0, halted=0.
  - stall and busy evaluate from RUN immediately.

## Timing
- Latency op→stall is 0 cycles (combinational); op→stall_pm is 1 cycle; HLT→halted is 1 cycle.
- Jump with default parameters: stall high in cycles T and T+1; low at T+2 (serviced); next op is evaluated at T+3.
- Load without macro, default parameters: stall high at T only; T+1 is serviced.
- resume arriving at T: stall low at T+1; halted low at T+1.
- With JUMP_BUBBLES=1, the JMP state lasts zero extra cycles: the cycle after T is the serviced RUN cycle.

## Configuration
- HAZARD_SEQ_LOAD_USE_EN undefined:
  - Every LD stalls unconditionally for LOAD_BUBBLES cycles, starting in its decode cycle.
  - Exits to serviced RUN.
- HAZARD_SEQ_LOAD_USE_EN defined:
  - LD decode does not stall. It captures ld_dst=rt and sets ld_pending=1 for the next cycle.
  - In the next RUN cycle, if ld_pending and ld_dst≠0 and (rs==ld_dst or rt==ld_dst):
    - stall LOAD_BUBBLES cycles for that consumer via the LD state;
    - clear ld_pending;
    - exit to RUN with serviced=0, so the consumer is then decoded normally (HLT/JUMP/LD).
  - Otherwise ld_pending clears after one cycle.
  - A stalled cycle does not consume ld_pending.

## Structure
- Shared package mips_ctrl_pkg:
  - OP_HLT, OP_LD, OP_JUMP_MASK, OP_JUMP_VAL
  - state enum hs_state_t
  - counter width constant HS_CNT_W=4
- Sub-module bubble_counter: load value, decrement, zero flag.
- Everything else stays in hazard_sequencer.

## Test plan
- Reset low mid-JMP (cnt=1) → stall=0, stall_pm=0, halted=0 immediately; after release, op=6'h00 gives stall=0.
- op=6'b011101 held, default parameters → stall=1,1,0 over three cycles; stall_pm=0,1,1,0.
- op=6'b010001 then resume pulse 5 cycles later → halted=1 from cycle 1 to 5; stall drops the cycle after resume; the held HLT does not retrigger.
- Macro off, op=6'b010100, LOAD_BUBBLES=3 → stall exactly 3 cycles, then 0.
- Macro on: LD with rt=5, then op=6'h00 with rs=5 → one stall on the consumer. The same sequence with rs=0, rt=0 → no stall. LD with rt=0 followed by consumer rs=0 → no stall.
- Macro on: LD rt=7, then JUMP with rt=7 → 1 load stall, then 2 jump stalls, total 3 consecutive.
